// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access pipeline stage: FSM state encoding,
// the default timeout load value and the dmem read/write encoding.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam logic [15:0] ERR_DATA_DEFAULT = 16'hDEAD;

    localparam logic WE_READ  = 1'b0;
    localparam logic WE_WRITE = 1'b1;

    // A TIMEOUT of 1 would otherwise give a zero-width counter.
    function automatic int ctrWidth(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Request/acknowledge data-memory port between the memory stage (master)
// and the variable-latency data memory (slave).
interface mem_access_stage_if #(
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_timeout_ctr.sv
// Clear/enable wait counter with a terminal-count flag; it saturates at
// TIMEOUT-1 so an aborted transaction never wraps back to zero.
module mem_timeout_ctr
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CW      = ctrWidth(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    assign tc_o = (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !tc_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-stage controller: turns EX/MEM load/store controls into a req/ack
// transaction, stalls the pipe while it is outstanding and aborts on timeout.
module mem_access_stage
    import mem_access_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_valid,
    input  logic              MEM_cntrl_mem_read,
    input  logic              MEM_cntrl_mem_write,
    input  logic [DATA_W-1:0] MEM_alu_result,
    input  logic [DATA_W-1:0] MEM_store_data,
    input  logic              MEM_hlt_in,
    mem_access_stage_if.master dmem,
    output logic [DATA_W-1:0] MEM_mem_output,
    output logic              mem_stall,
    output logic              MEM_hlt,
    output logic              timeout_err
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] WAIT = ST_WAIT;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              terr_q, terr_d;
    logic              access;
    logic              tmoTc;

    assign access = MEM_valid & (MEM_cntrl_mem_read | MEM_cntrl_mem_write);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr_i ((state_q == IDLE) & access),
        .en_i  ((state_q == WAIT) & ~dmem.ack),
        .tc_o  (tmoTc)
    );

    // we_q doubles as the load/store tag of the outstanding access, since
    // write wins whenever both controls are asserted.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        out_d   = out_q;
        terr_d  = terr_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    addr_d  = MEM_alu_result;
                    wdata_d = MEM_store_data;
                    req_d   = 1'b1;
                    we_d    = MEM_cntrl_mem_write ? WE_WRITE : WE_READ;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dmem.ack) begin
                    req_d   = 1'b0;
                    if (we_q == WE_READ) out_d = dmem.rdata;
                    state_d = DONE;
                end else if (tmoTc) begin
                    req_d   = 1'b0;
                    if (we_q == WE_READ) out_d = ERR_DATA;
                    terr_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            out_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            out_q   <= out_d;
            terr_q  <= terr_d;
        end
    end

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;

    // Gated by rst so a pending access cannot stall the pipe during reset.
    assign mem_stall      = ~rst & (((state_q == IDLE) & access) | (state_q == WAIT));
    assign MEM_hlt        = ~rst & MEM_hlt_in & ~mem_stall;
    assign MEM_mem_output = out_q;
    assign timeout_err    = terr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: a long-timeout instance (A) and a TIMEOUT=4
// instance (B), checked against a transaction-level expectation model.
module tb_mem_access_stage;

    localparam int TMO_A = 255;
    localparam int TMO_B = 4;

    logic        clk;
    logic        rst;
    logic        vld    [2];
    logic        rdCtl  [2];
    logic        wrCtl  [2];
    logic        hltIn  [2];
    logic [15:0] aluRes [2];
    logic [15:0] stData [2];
    logic [15:0] memOut [2];
    logic        stallO [2];
    logic        hltO   [2];
    logic        terrO  [2];

    logic [15:0] expOut  [2];
    logic        expTerr [2];
    int          checks;
    int          errors;

    mem_access_stage_if #(.DATA_W(16)) busA ();
    mem_access_stage_if #(.DATA_W(16)) busB ();

    mem_access_stage #(.DATA_W(16), .TIMEOUT(TMO_A), .ERR_DATA(16'hDEAD)) dutA (
        .clk                 (clk),
        .rst                 (rst),
        .MEM_valid           (vld[0]),
        .MEM_cntrl_mem_read  (rdCtl[0]),
        .MEM_cntrl_mem_write (wrCtl[0]),
        .MEM_alu_result      (aluRes[0]),
        .MEM_store_data      (stData[0]),
        .MEM_hlt_in          (hltIn[0]),
        .dmem                (busA.master),
        .MEM_mem_output      (memOut[0]),
        .mem_stall           (stallO[0]),
        .MEM_hlt             (hltO[0]),
        .timeout_err         (terrO[0])
    );

    mem_access_stage #(.DATA_W(16), .TIMEOUT(TMO_B), .ERR_DATA(16'hDEAD)) dutB (
        .clk                 (clk),
        .rst                 (rst),
        .MEM_valid           (vld[1]),
        .MEM_cntrl_mem_read  (rdCtl[1]),
        .MEM_cntrl_mem_write (wrCtl[1]),
        .MEM_alu_result      (aluRes[1]),
        .MEM_store_data      (stData[1]),
        .MEM_hlt_in          (hltIn[1]),
        .dmem                (busB.master),
        .MEM_mem_output      (memOut[1]),
        .mem_stall           (stallO[1]),
        .MEM_hlt             (hltO[1]),
        .timeout_err         (terrO[1])
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setAck(input int sel, input logic a, input logic [15:0] d);
        if (sel != 0) begin
            busB.ack   = a;
            busB.rdata = d;
        end else begin
            busA.ack   = a;
            busA.rdata = d;
        end
    endtask

    // One EX/MEM instruction on the selected instance. Entered and left at
    // posedge+1. An access finishes ackDelay+1 cycles after it is presented,
    // or TIMEOUT+1 cycles when the ack would come later than the last WAIT cycle.
    task automatic applyStimulus(input int sel, input logic v, input logic r, input logic w,
                                 input logic h, input logic [15:0] a, input logic [15:0] d,
                                 input int ackDelay, input logic [15:0] rdata);
        int          tmo;
        bit          isAcc;
        bit          isLoad;
        bit          timedOut;
        int          doneCyc;
        bit          expStall;
        bit          expReq;
        logic [15:0] obsReq;
        logic [15:0] obsWe;
        logic [15:0] obsAddr;
        logic [15:0] obsWdata;
        tmo      = (sel != 0) ? TMO_B : TMO_A;
        isAcc    = v && (r || w);
        isLoad   = isAcc && !w;
        timedOut = isAcc && (ackDelay < 1 || ackDelay > tmo);
        doneCyc  = !isAcc ? 0 : (timedOut ? tmo + 1 : ackDelay + 1);
        vld[sel]    = v;
        rdCtl[sel]  = r;
        wrCtl[sel]  = w;
        hltIn[sel]  = h;
        aluRes[sel] = a;
        stData[sel] = d;
        for (int c = 0; c <= doneCyc; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            setAck(sel, isAcc && !timedOut && (c == ackDelay), rdata);
            if (isAcc && c == doneCyc) begin
                if (isLoad) expOut[sel] = timedOut ? 16'hDEAD : rdata;
                if (timedOut) expTerr[sel] = 1'b1;
            end
            @(negedge clk);
            expStall = isAcc && (c < doneCyc);
            expReq   = isAcc && (c >= 1) && (c < doneCyc);
            obsReq   = {15'd0, (sel != 0) ? busB.req : busA.req};
            obsWe    = {15'd0, (sel != 0) ? busB.we : busA.we};
            obsAddr  = (sel != 0) ? busB.addr : busA.addr;
            obsWdata = (sel != 0) ? busB.wdata : busA.wdata;
            checkOutput("mem_stall", {15'd0, stallO[sel]}, {15'd0, expStall});
            checkOutput("dmem_req", obsReq, {15'd0, expReq});
            checkOutput("MEM_hlt", {15'd0, hltO[sel]}, {15'd0, h && !expStall});
            checkOutput("MEM_mem_output", memOut[sel], expOut[sel]);
            checkOutput("timeout_err", {15'd0, terrO[sel]}, {15'd0, expTerr[sel]});
            if (expReq) begin
                checkOutput("dmem_we", obsWe, {15'd0, w});
                checkOutput("dmem_addr", obsAddr, a);
                checkOutput("dmem_wdata", obsWdata, d);
            end
        end
        @(posedge clk);
        #1;
        setAck(sel, 1'b0, 16'h0000);
        vld[sel] = 1'b0;
    endtask

    initial begin
        logic r, w;
        int   kind;
        clk    = 1'b0;
        rst    = 1'b1;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 2; i++) begin
            vld[i]     = 1'b0;
            rdCtl[i]   = 1'b0;
            wrCtl[i]   = 1'b0;
            hltIn[i]   = 1'b0;
            aluRes[i]  = 16'h0000;
            stData[i]  = 16'h0000;
            expOut[i]  = 16'h0000;
            expTerr[i] = 1'b0;
        end
        setAck(0, 1'b0, 16'h0000);
        setAck(1, 1'b0, 16'h0000);

        // Reset held with a load pending: everything must read zero.
        vld[0]    = 1'b1;
        rdCtl[0]  = 1'b1;
        hltIn[0]  = 1'b1;
        aluRes[0] = 16'h0040;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_stall", {15'd0, stallO[0]}, 16'h0000);
        checkOutput("rst_hlt", {15'd0, hltO[0]}, 16'h0000);
        checkOutput("rst_req", {15'd0, busA.req}, 16'h0000);
        checkOutput("rst_we", {15'd0, busA.we}, 16'h0000);
        checkOutput("rst_addr", busA.addr, 16'h0000);
        checkOutput("rst_wdata", busA.wdata, 16'h0000);
        checkOutput("rst_out", memOut[0], 16'h0000);
        checkOutput("rst_terr", {15'd0, terrO[0]}, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] directed accesses");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 1, 16'h1234);
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 5, 16'h5555);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 100, 16'h7777);
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0102, 16'hCAFE, 2, 16'h0000);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0104, 16'h0000, 4, 16'h4321);
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0020, 16'hA5A5, 3, 16'h9999);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0030, 16'h1111, 1, 16'h2222);
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0030, 16'h1111, 1, 16'h2222);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4);
            r = (kind == 0 || kind == 2);
            w = (kind == 1 || kind == 2);
            if (n % 2 == 0)
                applyStimulus(0, ($urandom_range(0, 4) != 0), r, w, 1'($urandom),
                              16'($urandom), 16'($urandom), $urandom_range(1, 8), 16'($urandom));
            else
                applyStimulus(1, ($urandom_range(0, 4) != 0), r, w, 1'($urandom),
                              16'($urandom), 16'($urandom), $urandom_range(1, 6), 16'($urandom));
        end

        // Reset during the second WAIT cycle, then a late ack.
        $display("[TB] reset during WAIT");
        vld[0]    = 1'b1;
        rdCtl[0]  = 1'b1;
        wrCtl[0]  = 1'b0;
        hltIn[0]  = 1'b0;
        aluRes[0] = 16'h0200;
        @(negedge clk);
        checkOutput("rstw_stall0", {15'd0, stallO[0]}, 16'h0001);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        checkOutput("rstw_req_async", {15'd0, busA.req}, 16'h0000);
        vld[0] = 1'b0;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expOut[i]  = 16'h0000;
            expTerr[i] = 1'b0;
        end
        @(negedge clk);
        checkOutput("rstw_stall", {15'd0, stallO[0]}, 16'h0000);
        @(posedge clk);
        #1;
        setAck(0, 1'b1, 16'hFFFF);
        @(negedge clk);
        checkOutput("late_ack_stall", {15'd0, stallO[0]}, 16'h0000);
        checkOutput("late_ack_req", {15'd0, busA.req}, 16'h0000);
        @(posedge clk);
        #1;
        setAck(0, 1'b0, 16'h0000);
        @(negedge clk);
        checkOutput("late_ack_out", memOut[0], 16'h0000);
        checkOutput("rstw_terrB", {15'd0, terrO[1]}, 16'h0000);
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0300, 16'h0000, 1, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
